// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segments
);

  assign o_segments = HEX_SEG[i_nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scan driver.
// The divided scan clock is sampled as data, synchronised and edge-detected;
// each rising edge advances to the next digit through one blanking cycle.
// Optional build macro: SEG7_LEADING_ZERO_BLANK_EN darkens leading-zero digits.
//
//   state | meaning
//   BLANK | all anodes off for one cycle between digits (anti-ghosting)
//   DRIVE | current digit lit until the next scan tick
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      i_clk_in,
  input  logic                      i_reset,
  input  logic                      i_scan_clk,
  input  logic [NUM_DIGITS*4-1:0]   i_data_in,
  input  logic                      i_data_load,
  input  logic [NUM_DIGITS-1:0]     i_digit_en_in,
  input  logic [NUM_DIGITS-1:0]     i_dp_in,
  output logic [NUM_DIGITS-1:0]     o_anodes,
  output logic [6:0]                o_segments,
  output logic                      o_dp,
  output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     r_hist;
  logic                     w_tick;
  scan_state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]         r_idx, w_idx_nxt;
  logic [NUM_DIGITS*4-1:0]  r_shadow_data;
  logic [NUM_DIGITS-1:0]    r_shadow_en;
  logic [NUM_DIGITS-1:0]    r_shadow_dp;
  logic [NUM_DIGITS-1:0]    r_anodes, w_anodes_nxt;
  logic [6:0]               r_segments, w_segments_nxt;
  logic                     r_dp, w_dp_nxt;
  logic [3:0]               w_nibble;
  logic [6:0]               w_seg_pat;
  logic [NUM_DIGITS-1:0]    w_onehot;

  // Synchronise scan_clk and keep one history flop for rising-edge detect.
  always_ff @(posedge i_clk_in) begin
    if (!i_reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_scan_clk};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick = r_sync[SYNC_STAGES-1] & ~r_hist;

  // Shadow registers capture the display value on a load strobe.
  always_ff @(posedge i_clk_in) begin
    if (!i_reset) begin
      r_shadow_data <= '0;
      r_shadow_en   <= '1;
      r_shadow_dp   <= '0;
    end else if (i_data_load) begin
      r_shadow_data <= i_data_in;
      r_shadow_en   <= i_digit_en_in;
      r_shadow_dp   <= i_dp_in;
    end
  end

  // State and digit index register.
  always_ff @(posedge i_clk_in) begin
    if (!i_reset) begin
      r_state <= BLANK;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next state: BLANK always lasts one cycle; a tick advances the index in either state.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    if (w_tick) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end
    case (r_state)
      BLANK:   w_state_nxt = DRIVE;
      DRIVE:   if (w_tick) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
  end

  assign w_nibble = r_shadow_data[{r_idx, 2'b00} +: 4];

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble   (w_nibble),
    .o_segments (w_seg_pat)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0] w_msd;

  // Index of the most significant nonzero nibble; digit 0 always counts as shown.
  always_comb begin
    w_msd = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (r_shadow_data[k*4 +: 4] != 4'h0) w_msd = k[IDX_W-1:0];
    end
  end
`endif

  // Display pattern for the current state, registered below.
  always_comb begin
    w_onehot         = '0;
    w_onehot[r_idx]  = 1'b1;
    w_anodes_nxt     = '1;
    w_segments_nxt   = SEG_BLANK;
    w_dp_nxt         = 1'b1;
    if (r_state == DRIVE) begin
      w_anodes_nxt   = r_shadow_en[r_idx] ? ~w_onehot : '1;
      w_segments_nxt = w_seg_pat;
      w_dp_nxt       = ~r_shadow_dp[r_idx];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      // Leading zeros stay dark, but a set decimal point keeps the anode on.
      if (r_idx > w_msd) begin
        w_segments_nxt = SEG_BLANK;
        w_anodes_nxt   = (r_shadow_en[r_idx] && r_shadow_dp[r_idx]) ? ~w_onehot : '1;
      end
`endif
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk_in) begin
    if (!i_reset) begin
      r_anodes   <= '1;
      r_segments <= SEG_BLANK;
      r_dp       <= 1'b1;
    end else begin
      r_anodes   <= w_anodes_nxt;
      r_segments <= w_segments_nxt;
      r_dp       <= w_dp_nxt;
    end
  end

  assign o_anodes    = r_anodes;
  assign o_segments  = r_segments;
  assign o_dp        = r_dp;
  assign o_digit_idx = r_idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: reset, tick latency, full scan,
// load coincident with tick, masking/dp, leading-zero option, mid-scan reset.
module tb_seg7_scan_driver;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        scan_clk;
  logic [31:0] data_in;
  logic        data_load;
  logic [7:0]  digit_en_in;
  logic [7:0]  dp_in;
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic [2:0]  digit_idx;

  int n_chk = 0;
  int n_bad = 0;

  // Hand-derived patterns for 32'h89ABCDEF, digit 0 first.
  logic [6:0] seg_89 [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
  // Hand-derived patterns for 32'h00000120, digit 0 first.
  logic [6:0] seg_120 [8] = '{7'h40, 7'h24, 7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  seg7_scan_driver dut (
    .i_clk_in      (clk_in),
    .i_reset       (reset),
    .i_scan_clk    (scan_clk),
    .i_data_in     (data_in),
    .i_data_load   (data_load),
    .i_digit_en_in (digit_en_in),
    .i_dp_in       (dp_in),
    .o_anodes      (anodes),
    .o_segments    (segments),
    .o_dp          (dp),
    .o_digit_idx   (digit_idx)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One scan tick: check latency, the blanking cycle, then the new digit.
  task automatic step(input logic [2:0] exp_idx, input logic [7:0] exp_an,
                      input logic [6:0] exp_seg, input logic exp_dp);
    logic [2:0] prev;
    prev = exp_idx - 3'd1;
    @(negedge clk_in) scan_clk = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("idx_before_tick", digit_idx, prev);
    @(negedge clk_in);
    chk("idx_after_tick", digit_idx, exp_idx);
    @(negedge clk_in);
    chk("blank_anodes", anodes, 8'hFF);
    chk("blank_segs", segments, 7'h7F);
    @(negedge clk_in);
    chk("drive_anodes", anodes, exp_an);
    chk("drive_segs", segments, exp_seg);
    chk("drive_dp", dp, exp_dp);
    scan_clk = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  initial begin
    logic [7:0] an_e;
    logic [6:0] sg_e;
    int k;
    reset = 1'b0; scan_clk = 1'b0; data_in = '0; data_load = 1'b0;
    digit_en_in = 8'hFF; dp_in = 8'h00;

    // Reset held with scan_clk toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("rst_anodes", anodes, 8'hFF);
      chk("rst_segs", segments, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_idx", digit_idx, 3'd0);
      scan_clk = ~scan_clk;
    end
    scan_clk = 1'b0;
    @(negedge clk_in);

    // Release reset and load 89ABCDEF.
    reset = 1'b1;
    data_load = 1'b1; data_in = 32'h89ABCDEF; digit_en_in = 8'hFF; dp_in = 8'h00;
    @(negedge clk_in);
    data_load = 1'b0; data_in = 32'h0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("d0_anodes", anodes, 8'hFE);
    chk("d0_segs", segments, 7'h0E);
    chk("d0_dp", dp, 1'b1);

    // Falling edge alone must not tick.
    scan_clk = 1'b1;
    repeat (6) @(negedge clk_in);
    scan_clk = 1'b0;
    // the rising edge above ticked once to digit 1 -> verify, then fall produces nothing
    chk("rise_ticked_once", digit_idx, 3'd1);
    repeat (6) @(negedge clk_in);
    chk("no_tick_on_fall", digit_idx, 3'd1);
    chk("d1_anodes", anodes, 8'hFD);
    chk("d1_segs", segments, 7'h06);

    // Full scan continues: digits 2..7 then 0.
    for (int i = 2; i <= 8; i++) begin
      k = i % 8;
      an_e = 8'hFF;
      an_e[k] = 1'b0;
      step(k[2:0], an_e, seg_89[k], 1'b1);
    end

    // Advance to digit 7 for the coincident-load case.
    for (int i = 1; i <= 7; i++) begin
      an_e = 8'hFF;
      an_e[i] = 1'b0;
      step(i[2:0], an_e, seg_89[i], 1'b1);
    end

    // Load coincident with the tick into digit 0.
    @(negedge clk_in) scan_clk = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    data_load = 1'b1; data_in = 32'h00000005; digit_en_in = 8'hFF; dp_in = 8'h00;
    @(negedge clk_in);
    data_load = 1'b0; data_in = 32'hDEAD0000;
    chk("coinc_idx", digit_idx, 3'd0);
    @(negedge clk_in);
    chk("coinc_blank", anodes, 8'hFF);
    @(negedge clk_in);
    chk("coinc_anodes", anodes, 8'hFE);
    chk("coinc_segs", segments, 7'h12);
    scan_clk = 1'b0;
    repeat (2) @(negedge clk_in);

    // Masking and decimal point; data_in changes without a load are ignored.
    @(negedge clk_in);
    data_load = 1'b1; data_in = 32'h89ABCDEF; digit_en_in = 8'b11111101; dp_in = 8'b00000100;
    @(negedge clk_in);
    data_load = 1'b0; data_in = 32'h0; digit_en_in = 8'hFF; dp_in = 8'hFF;
    step(3'd1, 8'hFF, 7'h06, 1'b1);
    step(3'd2, 8'hFB, 7'h21, 1'b0);

    // Leading-zero option with 32'h00000120.
    @(negedge clk_in);
    data_load = 1'b1; data_in = 32'h00000120; digit_en_in = 8'hFF; dp_in = 8'h00;
    @(negedge clk_in);
    data_load = 1'b0; data_in = 32'h0;
    for (int i = 0; i < 8; i++) begin
      k = (3 + i) % 8;
      an_e = 8'hFF;
      an_e[k] = 1'b0;
      sg_e = seg_120[k];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (k > 2) begin
        an_e = 8'hFF;
        sg_e = 7'h7F;
      end
`endif
      step(k[2:0], an_e, sg_e, 1'b1);
    end

    // Reset in the middle of DRIVE abandons the digit at once.
    @(negedge clk_in);
    chk("pre_rst_anodes", anodes, 8'hFB);
    reset = 1'b0;
    @(negedge clk_in);
    chk("midrst_anodes", anodes, 8'hFF);
    chk("midrst_segs", segments, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    chk("midrst_idx", digit_idx, 3'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
